oflow_core_frame_sequencer: RTL

OFLOW_CORE_FRAME_SEQUENCER -- requirements
Module: oflow_core_frame_sequencer

---
 rtl/oflow_core_frame_sequencer.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/oflow_core_frame_sequencer.sv
// ---------------------------------------------------------------------------
// oflow_core_frame_sequencer
// Per-frame phase sequencer for the OFLOW core array. It accepts one frame
// request at a time and walks the datapath FSMs through READ -> SCORE ->
// CONFLICT -> WRITE. On the first frame after reset or flush there is no
// history, so SCORE and CONFLICT are skipped. Each phase is bounded by a
// cycle timeout that parks the block in ERR until clear_err.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   start_frame                frame request (accepted only in IDLE)
//   flush                      drop tracking history (IDLE only)
//   clear_err                  leave ERR
//   num_of_bbox_in_frame       bbox count, sampled with start_frame
//   done_read/score/conflict/write   phase-complete strobes
//   start_read/score/conflict/write  one-cycle phase start pulses
//   rows_in_frame              ceil(count / PE_NUM) of the accepted frame
//   busy, error, frame_done    status
//   history_valid, frame_cnt   previous-frame flag, completed frame count
//   err_phase                  phase that timed out (0..3 = READ..WRITE)
// ---------------------------------------------------------------------------
module oflow_core_frame_sequencer #(
  parameter int unsigned PE_NUM                     = 22,
  parameter int unsigned NUM_OF_BBOX_IN_FRAME_WIDTH = 10,
  parameter int unsigned TIMEOUT_CYCLES             = 4096,
  parameter int unsigned FRAME_CNT_WIDTH            = 16
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start_frame,
  input  logic                                  flush,
  input  logic                                  clear_err,
  input  logic [NUM_OF_BBOX_IN_FRAME_WIDTH-1:0] num_of_bbox_in_frame,
  input  logic                                  done_read,
  input  logic                                  done_score,
  input  logic                                  done_conflict,
  input  logic                                  done_write,
  output logic                                  start_read,
  output logic                                  start_score,
  output logic                                  start_conflict,
  output logic                                  start_write,
  output logic [NUM_OF_BBOX_IN_FRAME_WIDTH-1:0] rows_in_frame,
  output logic                                  busy,
  output logic                                  frame_done,
  output logic                                  history_valid,
  output logic [FRAME_CNT_WIDTH-1:0]            frame_cnt,
  output logic                                  error,
  output logic [1:0]                            err_phase
);

  localparam int unsigned NW  = NUM_OF_BBOX_IN_FRAME_WIDTH;
  localparam int unsigned FW  = FRAME_CNT_WIDTH;
  localparam int unsigned PCW = $clog2(TIMEOUT_CYCLES + 1);
  // Wide enough that n + PE_NUM - 1 cannot overflow.
  localparam int unsigned SW  = NW + $clog2(PE_NUM + 1) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_SCORE, S_CONFLICT, S_WRITE, S_DONE, S_ERR
  } state_t;

  state_t           state_q, state_d;
  logic [PCW-1:0]   phase_cnt_q;
  logic [NW-1:0]    rows_q;
  logic [FW-1:0]    frame_cnt_q, frame_cnt_d;
  logic             history_valid_q, history_valid_d;
  logic [1:0]       err_phase_q, err_phase_d;
  logic             start_read_q, start_score_q, start_conflict_q, start_write_q;
  logic             busy_q, frame_done_q, error_q;

  logic             accept;
  logic             flush_now;
  logic             timeout;
  logic             in_phase;
  logic             entering;
  logic [SW-1:0]    rows_sum;
  logic [NW-1:0]    rows_calc;

  assign accept    = (state_q == S_IDLE) && start_frame;
  assign flush_now = (state_q == S_IDLE) && flush;
  assign timeout   = (phase_cnt_q == PCW'(TIMEOUT_CYCLES - 1));
  assign in_phase  = (state_q == S_READ) || (state_q == S_SCORE) ||
                     (state_q == S_CONFLICT) || (state_q == S_WRITE);
  assign entering  = (state_d != state_q);

  // Ceiling division of the incoming count by the row width.
  assign rows_sum  = SW'(num_of_bbox_in_frame) + SW'(PE_NUM - 1);
  assign rows_calc = NW'(rows_sum / SW'(PE_NUM));

  // Next state, error phase capture and frame bookkeeping.
  always_comb begin
    state_d         = state_q;
    err_phase_d     = err_phase_q;
    frame_cnt_d     = flush_now ? '0 : frame_cnt_q;
    history_valid_d = flush_now ? 1'b0 : history_valid_q;

    case (state_q)
      S_IDLE: begin
        if (start_frame) begin
          state_d = (num_of_bbox_in_frame == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        // A done strobe in the timeout cycle takes priority.
        if (done_read) begin
          state_d = history_valid_q ? S_SCORE : S_WRITE;
        end else if (timeout) begin
          state_d     = S_ERR;
          err_phase_d = 2'd0;
        end
      end
      S_SCORE: begin
        if (done_score) begin
          state_d = S_CONFLICT;
        end else if (timeout) begin
          state_d     = S_ERR;
          err_phase_d = 2'd1;
        end
      end
      S_CONFLICT: begin
        if (done_conflict) begin
          state_d = S_WRITE;
        end else if (timeout) begin
          state_d     = S_ERR;
          err_phase_d = 2'd2;
        end
      end
      S_WRITE: begin
        if (done_write) begin
          state_d = S_DONE;
        end else if (timeout) begin
          state_d     = S_ERR;
          err_phase_d = 2'd3;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_ERR: begin
        if (clear_err) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Counter and history update land together with frame_done.
    if (state_d == S_DONE) begin
      frame_cnt_d     = frame_cnt_d + FW'(1);
      history_valid_d = 1'b1;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= S_IDLE;
      phase_cnt_q      <= '0;
      rows_q           <= '0;
      frame_cnt_q      <= '0;
      history_valid_q  <= 1'b0;
      err_phase_q      <= 2'd0;
      start_read_q     <= 1'b0;
      start_score_q    <= 1'b0;
      start_conflict_q <= 1'b0;
      start_write_q    <= 1'b0;
      busy_q           <= 1'b0;
      frame_done_q     <= 1'b0;
      error_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      frame_cnt_q     <= frame_cnt_d;
      history_valid_q <= history_valid_d;
      err_phase_q     <= err_phase_d;

      if (entering || !in_phase) begin
        phase_cnt_q <= '0;
      end else begin
        phase_cnt_q <= phase_cnt_q + PCW'(1);
      end

      if (accept) begin
        rows_q <= rows_calc;
      end

      start_read_q     <= entering && (state_d == S_READ);
      start_score_q    <= entering && (state_d == S_SCORE);
      start_conflict_q <= entering && (state_d == S_CONFLICT);
      start_write_q    <= entering && (state_d == S_WRITE);
      frame_done_q     <= (state_d == S_DONE);
      busy_q           <= (state_d != S_IDLE);
      error_q          <= (state_d == S_ERR);
    end
  end

  assign start_read     = start_read_q;
  assign start_score    = start_score_q;
  assign start_conflict = start_conflict_q;
  assign start_write    = start_write_q;
  assign rows_in_frame  = rows_q;
  assign busy           = busy_q;
  assign frame_done     = frame_done_q;
  assign history_valid  = history_valid_q;
  assign frame_cnt      = frame_cnt_q;
  assign error          = error_q;
  assign err_phase      = err_phase_q;

endmodule
